// File: rtl/router_pkg.sv
// router_pkg: shared constants and types for the 1x3 router.
//   NUM_PORTS    - number of destination FIFOs (addresses 2'b00..2'b10)
//   TIMEOUT      - consecutive unread valid cycles before a port soft reset
//   CNT_W        - width of the per-port timeout counter (2**CNT_W >= TIMEOUT)
//   ADDR_INVALID - header address that selects no FIFO; also the reset value
//   port_addr_t  - 2-bit destination address type
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam int TIMEOUT   = 30;
  localparam int CNT_W     = 5;

  typedef logic [1:0] port_addr_t;

  localparam port_addr_t ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_sync_timer.sv
// router_sync_timer: per-port unread-data watchdog.
// Counts consecutive cycles where the port has valid data but the
// destination does not read it. After TIMEOUT such edges it emits a
// single-cycle soft_reset pulse and restarts counting from zero.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous, active-high reset
//   vld        in  port has data available (FIFO not empty)
//   read_enb   in  destination reads the port this cycle
//   soft_reset out registered one-cycle soft reset pulse
module router_sync_timer
  import router_pkg::*;
#(
  parameter int P_TIMEOUT = TIMEOUT,
  parameter int P_CNT_W   = CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic vld,
  input  logic read_enb,
  output logic soft_reset
);

  localparam logic [P_CNT_W-1:0] LAST = P_CNT_W'(P_TIMEOUT - 1);

  logic [P_CNT_W-1:0] r_cnt;
  logic               r_soft_reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (!vld || read_enb) begin
      // Nothing pending, or the destination drained a byte: restart.
      r_cnt        <= '0;
      r_soft_reset <= 1'b0;
    end else if (r_cnt == LAST) begin
      // TIMEOUT-th consecutive stalled edge: pulse and start a new window.
      r_cnt        <= '0;
      r_soft_reset <= 1'b1;
    end else begin
      r_cnt        <= r_cnt + 1'b1;
      r_soft_reset <= 1'b0;
    end
  end

  assign soft_reset = r_soft_reset;

endmodule

// File: rtl/router_sync.sv
// router_sync: address latch and port synchronisation for the 1x3 router.
// Latches the header destination address, steers the FSM write strobe to
// exactly one FIFO, reports that FIFO's full flag, drives per-port valid
// outputs and runs one unread-data watchdog per port.
//
// Write handshake: write_enb_reg is a single-cycle request; the selected
// FIFO sees it the same cycle on write_enb[addr]. The FSM must not assert
// write_enb_reg while fifo_full is high. An invalid address (2'b11) drops
// every write and reports fifo_full=0 so the packet drains silently.
//
// Ports:
//   clk           in  system clock
//   reset         in  synchronous, active-high reset
//   detect_add    in  data_in carries the header address this cycle
//   data_in[1:0]  in  destination address
//   write_enb_reg in  FSM write request for the current byte
//   read_enb[2:0] in  per-port read enable from the destinations
//   empty[2:0]    in  per-port FIFO empty flags
//   full[2:0]     in  per-port FIFO full flags
//   write_enb[2:0]  out one-hot FIFO write enable
//   fifo_full       out full flag of the selected FIFO
//   vld_out[2:0]    out per-port data available
//   soft_reset[2:0] out per-port watchdog soft reset pulse
module router_sync
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic [2:0] read_enb,
  input  logic [2:0] empty,
  input  logic [2:0] full,
  output logic [2:0] write_enb,
  output logic       fifo_full,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset
);

  port_addr_t r_addr;
  logic [2:0] w_write_enb;
  logic       w_fifo_full;
  logic [2:0] w_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= ADDR_INVALID;
    end else if (detect_add) begin
      r_addr <= data_in;
    end
  end

  // Decodes the already-latched address, so a header arriving together
  // with a write request only takes effect from the following cycle.
  always_comb begin
    w_write_enb = 3'b000;
    w_fifo_full = 1'b0;
    case (r_addr)
      2'b00: begin
        w_write_enb = {2'b00, write_enb_reg};
        w_fifo_full = full[0];
      end
      2'b01: begin
        w_write_enb = {1'b0, write_enb_reg, 1'b0};
        w_fifo_full = full[1];
      end
      2'b10: begin
        w_write_enb = {write_enb_reg, 2'b00};
        w_fifo_full = full[2];
      end
      default: begin
        w_write_enb = 3'b000;
        w_fifo_full = 1'b0;
      end
    endcase
  end

  // Not gated by reset: valid tracks the FIFOs directly.
  assign w_vld = ~empty;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_timer
    router_sync_timer #(
      .P_TIMEOUT (TIMEOUT),
      .P_CNT_W   (CNT_W)
    ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .vld        (w_vld[g]),
      .read_enb   (read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end

  assign write_enb = w_write_enb;
  assign fifo_full = w_fifo_full;
  assign vld_out   = w_vld;

endmodule

// File: tb/tb_router_sync.sv
// Directed testbench for router_sync.
module tb_router_sync;

  logic       clk;
  logic       reset;
  logic       detect_add;
  logic [1:0] data_in;
  logic       write_enb_reg;
  logic [2:0] read_enb;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] write_enb;
  logic       fifo_full;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;

  int n_tests = 0;
  int n_fail  = 0;

  router_sync dut (
    .clk           (clk),
    .reset         (reset),
    .detect_add    (detect_add),
    .data_in       (data_in),
    .write_enb_reg (write_enb_reg),
    .read_enb      (read_enb),
    .empty         (empty),
    .full          (full),
    .write_enb     (write_enb),
    .fifo_full     (fifo_full),
    .vld_out       (vld_out),
    .soft_reset    (soft_reset)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: advance one rising edge, land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
    read_enb = 3'b000; empty = 3'b111; full = 3'b111;

    // Reset with full and write request asserted.
    tick(); tick();
    chk("rst_write_enb", 32'(write_enb), 32'h0);
    chk("rst_fifo_full", 32'(fifo_full), 32'h0);
    chk("rst_soft_reset", 32'(soft_reset), 32'h0);
    empty = 3'b010; #1;
    chk("rst_vld_out", 32'(vld_out), 32'h5);
    empty = 3'b111; #1;
    chk("rst_vld_out_all_empty", 32'(vld_out), 32'h0);

    // Steering to port 1.
    reset = 1'b0; write_enb_reg = 1'b0; full = 3'b000;
    detect_add = 1'b1; data_in = 2'b01;
    tick();
    detect_add = 1'b0; data_in = 2'b00; write_enb_reg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("steer_write_enb_%0d", i), 32'(write_enb), 32'h2);
      chk($sformatf("steer_fifo_full_%0d", i), 32'(fifo_full), 32'h0);
      tick();
    end
    full = 3'b010; #1;
    chk("steer_full_sel", 32'(fifo_full), 32'h1);
    full = 3'b101; #1;
    chk("steer_full_other", 32'(fifo_full), 32'h0);
    write_enb_reg = 1'b0; #1;
    chk("steer_no_req", 32'(write_enb), 32'h0);

    // Invalid address drops writes.
    detect_add = 1'b1; data_in = 2'b11;
    tick();
    detect_add = 1'b0; write_enb_reg = 1'b1; full = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("inv_write_enb_%0d", i), 32'(write_enb), 32'h0);
      chk($sformatf("inv_fifo_full_%0d", i), 32'(fifo_full), 32'h0);
      tick();
    end

    // Same-cycle latch: old address 00 used, 10 from next cycle.
    write_enb_reg = 1'b0;
    detect_add = 1'b1; data_in = 2'b00;
    tick();
    detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1; full = 3'b001; #1;
    chk("same_cycle_old", 32'(write_enb), 32'h1);
    chk("same_cycle_old_full", 32'(fifo_full), 32'h1);
    tick();
    detect_add = 1'b0; full = 3'b011; #1;
    chk("same_cycle_new", 32'(write_enb), 32'h4);
    chk("same_cycle_new_full", 32'(fifo_full), 32'h0);
    full = 3'b100; #1;
    chk("same_cycle_new_full_set", 32'(fifo_full), 32'h1);
    write_enb_reg = 1'b0; full = 3'b000;

    // Timeout on port 0: pulses after edge 30 and edge 60 only.
    empty = 3'b110; read_enb = 3'b000; #1;
    chk("to_vld_out", 32'(vld_out), 32'h1);
    for (int e = 1; e <= 61; e++) begin
      tick();
      chk($sformatf("to_edge_%0d", e), 32'(soft_reset),
          (e == 30 || e == 60) ? 32'h1 : 32'h0);
    end

    // Restart: read at count 20 (edge 21), pulse at edge 51 only.
    empty = 3'b111;
    tick();
    empty = 3'b110;
    for (int e = 1; e <= 53; e++) begin
      read_enb = (e == 21) ? 3'b001 : 3'b000;
      tick();
      chk($sformatf("rs_edge_%0d", e), 32'(soft_reset), (e == 51) ? 32'h1 : 32'h0);
    end
    read_enb = 3'b000;

    // Reset mid-count: count restarts from the reset edge.
    empty = 3'b111;
    tick();
    empty = 3'b110;
    for (int e = 1; e <= 15; e++) tick();
    reset = 1'b1;
    tick();
    chk("mr_soft_reset", 32'(soft_reset), 32'h0);
    reset = 1'b0; write_enb_reg = 1'b1; #1;
    chk("mr_write_enb", 32'(write_enb), 32'h0);
    write_enb_reg = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk($sformatf("mr_edge_%0d", e), 32'(soft_reset), (e == 30) ? 32'h1 : 32'h0);
    end

    // All three ports time out together; port 1 restarted once.
    empty = 3'b111;
    tick();
    empty = 3'b000;
    for (int e = 1; e <= 35; e++) begin
      read_enb = (e == 3) ? 3'b010 : 3'b000;
      tick();
      chk($sformatf("all_edge_%0d", e), 32'(soft_reset),
          (e == 30) ? 32'h5 : (e == 33) ? 32'h2 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_sync.md
# router_sync

Address-latch and port-synchronisation stage of the 1x3 router. It sits directly upstream of the three per-port router_fifo instances, between the router FSM and the FIFOs. It latches the destination address from the packet header and steers the FSM's write strobe to exactly one FIFO. It also reports the selected FIFO's full status back to the FSM, drives per-port valid outputs, and issues a per-port soft_reset when a destination leaves data unread for too long.

## Interface
- NUM_PORTS, 3, number of destination FIFOs; fixed at 3, addresses 2'b00..2'b10.
- TIMEOUT, 30, consecutive unread valid cycles before soft_reset fires.
- CNT_W, 5, timeout counter width; must satisfy 2**CNT_W >= TIMEOUT.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  FSM strobe: data_in carries the header address this cycle.
- data_in  in  2  destination address (header bits [1:0]).
- write_enb_reg  in  1  FSM request to write the current byte into the selected FIFO.
- read_enb  in  3  per-port read enable from the destination.
- empty  in  3  per-port FIFO empty flag.
- full  in  3  per-port FIFO full flag.
- write_enb  out  3  one-hot FIFO write enable, wired to each router_fifo write_enb.
- fifo_full  out  1  full flag of the currently selected FIFO.
- vld_out  out  3  per-port data-available indication.
- soft_reset  out  3  per-port soft reset, wired to each router_fifo soft_reset.

## Operation
- addr_reg (2 bits): on an edge with detect_add=1, addr_reg <= data_in; otherwise it holds.
- Reset value of addr_reg is 2'b11 (ADDR_INVALID).
- write_enb (combinational): bit addr_reg = write_enb_reg when addr_reg is in 0..2; all zero when addr_reg = 2'b11.
- fifo_full (combinational): full[addr_reg]; 0 when addr_reg = 2'b11.
- Header address 2'b11 is invalid. No FIFO is written, fifo_full=0, and the packet is silently dropped.
- vld_out[i] = ~empty[i] (combinational).
- Per-port timer i: counter cnt_i (CNT_W bits) and a registered soft_reset[i].
  - vld_out[i]=0: cnt_i <= 0, soft_reset[i] <= 0.
  - vld_out[i]=1 and read_enb[i]=1: cnt_i <= 0, soft_reset[i] <= 0.
  - vld_out[i]=1, read_enb[i]=0, cnt_i < TIMEOUT-1: cnt_i <= cnt_i+1, soft_reset[i] <= 0.
  - vld_out[i]=1, read_enb[i]=0, cnt_i == TIMEOUT-1: cnt_i <= 0, soft_reset[i] <= 1.
- The three timers are fully independent; any combination of ports may time out in the same cycle.

## Timing
- Reset (synchronous): after the edge with reset=1, addr_reg=2'b11, every cnt_i=0, soft_reset=3'b000, write_enb=3'b000, fifo_full=0.
- vld_out follows empty combinationally even during reset.
- Address latch latency is one edge. When detect_add and write_enb_reg are both asserted in the same cycle, write_enb decodes the old addr_reg; the new address takes effect from the next cycle.
- write_enb and fifo_full have zero-cycle latency from write_enb_reg, addr_reg and full.
- soft_reset[i] rises after the TIMEOUT-th consecutive edge on which vld_out[i]=1 and read_enb[i]=0.
- soft_reset is a single-cycle pulse. If the FIFO stays non-empty, a further pulse follows TIMEOUT cycles later.
- A single read_enb[i]=1 cycle restarts the count from 0.
- Reset asserted mid-count clears the count; no pulse is emitted on or after the reset edge.

## Structure
- Shared package router_pkg holds:
  - NUM_PORTS, TIMEOUT and CNT_W defaults.
  - ADDR_INVALID = 2'b11.
  - typedef port_addr_t (2 bits).
- Sub-module router_sync_timer (ports: clk, reset, vld, read_enb, soft_reset) holds one counter and its soft_reset register. It is instantiated NUM_PORTS times.
- The top level holds addr_reg, the write_enb decode and the fifo_full mux.

## Test plan
- Reset: assert reset for 2 cycles with full=3'b111 and write_enb_reg=1. Required: write_enb=000, fifo_full=0, soft_reset=000.
- Steering: pulse detect_add with data_in=2'b01, then write_enb_reg=1 for 4 cycles. Required: write_enb=3'b010 on each of those cycles; full=3'b010 gives fifo_full=1.
- Invalid address: detect_add with data_in=2'b11, then write_enb_reg=1. Required: write_enb=000 and fifo_full=0 throughout.
- Timeout: empty[0]=0 and read_enb[0]=0 held. Required: soft_reset[0] high for exactly one cycle after the 30th edge and 0 on the 29th and 31st; ports 1 and 2 stay 0.
- Restart: as the Timeout case but read_enb[0]=1 for one cycle at count 20. Required: no pulse at edge 30; pulse 30 edges after the read.
- Same-cycle latch: addr_reg=00, then detect_add with data_in=2'b10 and write_enb_reg=1 in the same cycle. Required: write_enb=001 that cycle and 100 on the next write cycle.
